gray_cnt_arb: RTL
=================

Name: gray_cnt_arb

Overview:
- Bank of M independent N-bit Gray-code event counters sharing one Gray increment datapath: Gray-to-binary, +1, binary-to-Gray.
- Round-robin arbiter grants at most one channel per cycle. The granted channel's stored Gray value is advanced through the shared datapath.
- Used where several event sources need glitch-safe Gray counts (pointer/status export) without replicating increment logic per channel.

Parameters:
- N, 4, counter width in bits per channel (N >= 2)
- M, 4, number of requesting channels (M >= 2)

Ports:
- clk    input   1    rising-edge clock
- rstn   input   1    asynchronous active-low reset
- req    input   M    per-channel increment request, level; hold until gnt seen
- clr    input   M    per-channel synchronous clear to zero
- gnt    output  M    registered one-hot acknowledge, 1-cycle pulse: channel's increment has been applied
- wrap   output  M    registered 1-cycle pulse alongside gnt when that increment rolled the counter over to zero
- cnt    output  M*N  flattened Gray counts, channel i at cnt[i*N +: N], registered
- busy   output  1    registered; 1 when any channel was granted this cycle (equals |gnt)

Behaviour:
- Reset (rstn=0, asynchronous): all cnt = 0, gnt = 0, wrap = 0, busy = 0. Round-robin pointer = M-1, so channel 0 has first priority. Reset mid-operation discards pending requests; nothing is remembered.
- Eligibility per cycle: channel i is eligible iff req[i]=1 && clr[i]=0 && gnt[i]=0. While gnt[i] is high, req[i] is ignored that cycle. A requester holding req continuously is therefore incremented at most every other cycle.
- Arbitration is combinational over eligible channels. Search starts at (ptr+1) mod M and wraps around; the first eligible channel wins. ptr updates to the winner index only on a grant and holds otherwise.
- Increment: winner's cnt g is converted to binary b, with b[N-1]=g[N-1] and b[k]=b[k+1]^g[k]. Then b'=(b+1) mod 2^N, and the new Gray value is b' ^ (b'>>1). It is written into that channel's cnt at the clock edge.
- Latency: req sampled at edge k produces updated cnt, gnt and wrap all visible after edge k (same cycle). No channel's cnt changes other than the winner's or a cleared one's.
- Wrap: wrap[i]=1 with gnt[i] iff the pre-increment Gray value was gray(2^N-1). That value is 1 followed by N-1 zeros; for N=4 it is 1000. The new value is then 0.
- Clear: clr[i]=1 forces cnt[i] to 0 at the next edge and masks channel i from arbitration, so no gnt[i] or wrap[i] that cycle. Clear of one channel does not block grants to others.
- Simultaneous req and clr on the same channel: clear wins. The request remains pending if req is still held next cycle.
- No requests: all outputs except cnt go to 0; cnt holds.
- Every cnt bit transition caused by an increment changes exactly one bit of that channel's value.

Test Plan:
- Reset/basic: hold rstn=0 2 cycles, then release with req=0 -> cnt=0 for all channels, gnt=0, busy=0. Assert rstn=0 asynchronously mid-cycle after counts are nonzero -> all cnt=0 immediately, without waiting for a clock edge.
- Single channel sequence: N=4, req[0] held -> gnt[0] on alternate cycles. cnt[3:0] steps 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100. Checker verifies a single-bit change per increment and that other channels stay 0.
- Wrap: drive 15 grants to channel 2 -> cnt = 1000. The 16th grant -> cnt = 0000 with wrap[2]=1 for exactly that cycle, and wrap=0 on every other grant.
- Round-robin fairness: req=1111 held from reset -> grant order 0,1,2,3,0,1,... with one grant per cycle and busy=1 continuously. After 8 cycles every channel has count gray(2)=0011.
- Clear priority: channel 1 at 0110 with req[1]=1 and clr[1]=1 in the same cycle, req[3]=1 -> cnt[1]=0000, no gnt[1], gnt[3]=1. Next cycle with clr[1]=0 -> channel 1 granted, cnt[1]=0001.
- Pointer hold: grant channel 2, idle 5 cycles, then assert req=1111 -> first grant goes to channel 3 and the next to channel 0.

Source files
------------

// File: rtl/gray_cnt_arb.sv
// Bank of M Gray-code event counters advanced one channel per cycle through a
// single shared Gray->binary, +1, binary->Gray datapath, picked by a round-robin arbiter.
module gray_cnt_arb #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [M-1:0]   req,
  input  logic [M-1:0]   clr,
  output logic [M-1:0]   gnt,
  output logic [M-1:0]   wrap,
  output logic [M*N-1:0] cnt,
  output logic           busy
);

  localparam int unsigned PtrW = (M > 1) ? $clog2(M) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  logic [M*N-1:0] cnt_q, cnt_d;
  logic [M-1:0]   gnt_q, gnt_d;
  logic [M-1:0]   wrap_q, wrap_d;
  logic           busy_q, busy_d;
  ptr_t           ptr_q, ptr_d;

  logic [M-1:0]   elig;
  logic           win_found;
  ptr_t           win_idx;
  ptr_t           cand;
  logic [N-1:0]   sel_g;
  logic [N-1:0]   sel_b;
  logic [N-1:0]   inc_b;
  logic [N-1:0]   new_g;
  logic           sel_wrap;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int k = int'(N) - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // A channel just acknowledged sits out one cycle so a held req is not double-counted.
  assign elig = req & ~clr & ~gnt_q;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= M; k++) begin
      cand = ptr_t'((32'(ptr_q) + k) % M);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Shared increment datapath, fed by the winner's stored Gray value.
  always_comb begin
    sel_g    = cnt_q[win_idx*N +: N];
    sel_b    = gray2bin(sel_g);
    inc_b    = sel_b + {{(N-1){1'b0}}, 1'b1};
    new_g    = inc_b ^ (inc_b >> 1);
    sel_wrap = &sel_b;
  end

  always_comb begin
    cnt_d  = cnt_q;
    gnt_d  = '0;
    wrap_d = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (clr[i]) begin
        cnt_d[i*N +: N] = '0;
      end else if (win_found && (win_idx == ptr_t'(i))) begin
        cnt_d[i*N +: N] = new_g;
        gnt_d[i]        = 1'b1;
        wrap_d[i]       = sel_wrap;
      end
    end
    busy_d = win_found;
    ptr_d  = win_found ? win_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      gnt_q  <= '0;
      wrap_q <= '0;
      busy_q <= 1'b0;
      ptr_q  <= ptr_t'(M - 1);
    end else begin
      cnt_q  <= cnt_d;
      gnt_q  <= gnt_d;
      wrap_q <= wrap_d;
      busy_q <= busy_d;
      ptr_q  <= ptr_d;
    end
  end

  assign cnt  = cnt_q;
  assign gnt  = gnt_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
  a_busy_match : assert property (@(posedge clk) disable iff (!rstn) busy == |gnt);
  a_wrap_in_gnt : assert property (@(posedge clk) disable iff (!rstn) (wrap & ~gnt) == '0);
`endif

endmodule
